// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate one-word-line data cache controller.
// Optional hit/miss statistics counters are enabled by defining DATA_CACHE_STATS_EN.
module data_cache_ctrl #(
  parameter int LINES       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 30 - IDXW;
  localparam int CW   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WTHRU, RESP} state_t;

  state_t            state, state_nxt;
  logic [29:0]       waddr;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [LINES-1:0]  valid;
  logic [31:0]       data_arr [LINES];
  logic [TAGW-1:0]   tag_arr  [LINES];
  logic              flush_pend;
  logic [CW-1:0]     tmo_cnt;
  logic [31:0]       resp_data;
  logic              resp_err;

  logic [IDXW-1:0]   idx;
  logic [TAGW-1:0]   tag;
  logic              hit, flush_now, accept, tmo, waiting;
  logic              fill_wr, hit_wr;
  logic              unused_ok;

  // Byte offset is irrelevant for one-word lines.
  assign unused_ok = ^cpu_addr[1:0];

  assign idx       = waddr[IDXW-1:0];
  assign tag       = waddr[29:IDXW];
  assign hit       = valid[idx] && (tag_arr[idx] == tag);
  // Flush (live or pending) wins over a request in IDLE; the request is taken next cycle.
  assign flush_now = (state == IDLE) && (flush || flush_pend);
  assign accept    = (state == IDLE) && cpu_req && !flush_now;
  assign waiting   = (state == FILL) || (state == WTHRU);
  assign tmo       = (tmo_cnt == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    cpu_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_wr   = 1'b0;
    hit_wr    = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = LOOKUP;
      LOOKUP: begin
        if (we_q) begin
          hit_wr    = hit;
          state_nxt = WTHRU;
        end else if (hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = data_arr[idx];
          state_nxt = IDLE;
        end else begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {waddr, 2'b00};
        if (mem_ack) begin
          fill_wr   = 1'b1;
          state_nxt = RESP;
        end else if (tmo) begin
          state_nxt = RESP;
        end
      end
      WTHRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {waddr, 2'b00};
        mem_wdata = wdata_q;
        if (mem_ack || tmo) state_nxt = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = resp_data;
        cpu_err   = resp_err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
      tmo_cnt    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        waddr   <= cpu_addr[31:2];
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      if (flush_now)    valid      <= '0;
      else if (fill_wr) valid[idx] <= 1'b1;
      if (flush_now)    flush_pend <= 1'b0;
      else if (flush)   flush_pend <= 1'b1;
      tmo_cnt <= (waiting && !mem_ack && !tmo) ? tmo_cnt + 1'b1 : '0;
      if (waiting) begin
        if (mem_ack) begin
          resp_data <= (state == FILL) ? mem_rdata : '0;
          resp_err  <= 1'b0;
        end else if (tmo) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_arr[idx] <= mem_rdata;
      tag_arr[idx]  <= tag;
    end else if (hit_wr) begin
      data_arr[idx] <= wdata_q;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush_now) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_count != 16'hFFFF)        hit_count  <= hit_count + 16'd1;
      else if (!hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped one-word lines (power of 2, 4..64).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, max cycles waiting for mem_ack before error.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: cpu_req  in  1  CPU access request; held until cpu_ready.
REQ-006 SHALL have ports: cpu_we  in  1  1=write, 0=read; stable while cpu_req.
REQ-007 SHALL have ports: cpu_addr  in  32  byte address; word index = cpu_addr[2+log2(LINES)-1:2], tag = remaining upper bits.
REQ-008 SHALL have ports: cpu_wdata  in  32  write data.
REQ-009 SHALL have ports: cpu_rdata  out  32  read data, valid when cpu_ready.
REQ-010 SHALL have ports: cpu_ready  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: cpu_err  out  1  one-cycle pulse with cpu_ready on memory timeout.
REQ-012 SHALL have ports: flush  in  1  invalidate all lines.
REQ-013 SHALL have ports: mem_req, mem_we  out  1 each  backing-memory request/direction.
REQ-014 SHALL have ports: mem_addr, mem_wdata  out  32 each  word-aligned address, write data.
REQ-015 SHALL have ports: mem_rdata  in  32; mem_ack  in  1  one-cycle completion from memory.
REQ-016 SHALL have ports: hit_count, miss_count  out  16 each  statistics (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, LOOKUP, FILL, WTHRU, RESP.
REQ-018 IDLE: cpu_req=1 and flush=0 -> LOOKUP; address, we, wdata registered.
REQ-019 LOOKUP read hit (valid and tag match) -> cpu_ready=1, cpu_rdata=line data this cycle, -> IDLE; read-hit latency 2 cycles from cpu_req.
REQ-020 LOOKUP read miss -> FILL; mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00} held until mem_ack.
REQ-021 FILL on mem_ack: line data=mem_rdata, tag written, valid=1, -> RESP; RESP drives cpu_ready=1 with fill data, -> IDLE.
REQ-022 LOOKUP write (hit or miss) -> WTHRU; write-through, no-write-allocate; hit updates line data in LOOKUP cycle; miss leaves arrays unchanged.
REQ-023 WTHRU: mem_req=1, mem_we=1, mem_wdata=registered wdata until mem_ack, then -> RESP.
REQ-024 Timeout counter counts FILL/WTHRU cycles; at MEM_TIMEOUT: drop mem_req, no line update, -> RESP with cpu_err=1, cpu_rdata=0.
REQ-025 flush in IDLE clears all valid bits in one cycle; flush outside IDLE is held pending and applied on return to IDLE; flush and cpu_req together in IDLE: flush first, request accepted next cycle.
REQ-026 mem_ack outside FILL/WTHRU SHALL be ignored; mem_req SHALL never be asserted in IDLE, LOOKUP or RESP.
REQ-027 cpu_ready SHALL not assert in consecutive cycles; cpu_rdata=0 whenever cpu_ready=0.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, all valid bits 0, pending flush 0, timeout counter 0.
REQ-029 During reset all outputs SHALL be 0; reset mid-FILL/WTHRU drops mem_req with no line update.
REQ-030 Data and tag arrays need not be reset.

Configuration
REQ-031 Macro DATA_CACHE_STATS_EN defined: hit_count increments on each LOOKUP hit (read or write), miss_count on each LOOKUP miss, both saturate at 16'hFFFF and clear on reset and on flush.
REQ-032 Macro absent: hit_count and miss_count SHALL be constant 0 and no counter logic synthesized; all other behaviour identical.

Verification
REQ-033 Reset, cpu_req read addr 0x1, mem_rdata=0 ack after 3 cycles -> mem_addr=0x0, miss, cpu_ready with cpu_rdata=0; repeat -> hit, cpu_ready 2 cycles after cpu_req, no mem_req.
REQ-034 Write 7 to addr 0x1 (line valid) -> mem_we=1, mem_wdata=7; next read addr 0x1 -> hit, cpu_rdata=7, no mem_req.
REQ-035 LINES=16: read 0x20 (fill 3), read 0x60 (fill 9, same index 8) -> miss, evicts; read 0x20 -> miss again, returns 3.
REQ-036 Write 3 to uncached 0x24 -> write-through only; read 0x24 -> miss, mem read issued.
REQ-037 mem_ack withheld -> cpu_ready and cpu_err at timeout (256th FILL cycle), mem_req low after; flush+cpu_req same cycle -> prior hit address now misses.
REQ-038 With DATA_CACHE_STATS_EN: REQ-033 sequence -> hit_count=1, miss_count=1; after flush both 0; without macro both always 0.
